keypad_scan: RTL and testbench

//  4x4 hex matrix keypad scanner: the input-side counterpart of the 8-digit LED scan display.

---
 rtl/keypad_scan.sv | 160 ++++++++++++++++
 tb/tb_keypad_scan.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// 4x4 hex matrix keypad scanner.
// Drives one row low per scan slot and samples the synchronised columns.
// Presses and releases are debounced over several slot ticks. Each confirmed
// key is reported as a one-cycle pulse with its code and shifted into a
// 32-bit hex entry register.
module keypad_scan #(
  parameter int SCAN_DIV = 1000,  // clk cycles per row slot (>=2)
  parameter int DEBOUNCE = 4      // ticks needed to confirm press/release (>=1)
) (
  input  logic        clk,
  input  logic        rst,          // synchronous, active-low
  input  logic [3:0]  col_i,        // active-low columns, asynchronous
  output logic [3:0]  row_o,        // active-low row drive
  output logic        key_valid_o,  // one-cycle confirm pulse
  output logic [3:0]  key_code_o,   // row*4+col of last confirmed key
  output logic [31:0] value_o       // hex entry, newest digit in [3:0]
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HOLD
  } state_e;

  // Index of the lowest column pulled low; other simultaneous keys are ignored.
  function automatic logic [1:0] lowest_zero(input logic [3:0] c);
    lowest_zero = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!c[i]) lowest_zero = 2'(i);
    end
  endfunction

  state_e         state_q, state_d;
  logic [3:0]     col_meta_q, col_s_q;
  logic [DW-1:0]  div_q, div_d;
  logic [1:0]     r_q, r_d;
  logic [3:0]     row_q, row_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     kr_q, kr_d;
  logic [1:0]     kc_q, kc_d;
  logic [3:0]     code_q, code_d;
  logic [31:0]    value_q, value_d;
  logic           valid_q, valid_d;

  logic           tick;
  logic           col_kc;

  assign tick   = (div_q == DIV_LAST);
  assign col_kc = col_s_q[kc_q];

  // Two-flop synchroniser for the asynchronous column inputs.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clk) begin
    if (!rst) begin
      col_meta_q <= 4'hF;
      col_s_q    <= 4'hF;
    end else begin
      col_meta_q <= col_i;
      col_s_q    <= col_meta_q;
    end
  end

  // Next-state logic: slot divider, row index, debounce FSM and entry register.
  // NOTE: every variable gets a default before the case so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + DW'(1);
    r_d     = r_q;
    cnt_d   = cnt_q;
    kr_d    = kr_q;
    kc_d    = kc_q;
    code_d  = code_q;
    value_d = value_q;
    valid_d = 1'b0;

    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (col_s_q == 4'hF) begin
            r_d = r_q + 2'd1;
          end else begin
            kr_d    = r_q;
            kc_d    = lowest_zero(col_s_q);
            cnt_d   = CW'(1);
            state_d = ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (col_kc) begin
            r_d     = r_q + 2'd1;
            state_d = ST_SCAN;
          end else if (cnt_q == CNT_DONE) begin
            code_d  = {kr_q, kc_q};
            value_d = {value_q[27:0], kr_q, kc_q};
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = ST_HOLD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_HOLD: begin
          if (col_kc) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q + CW'(1) == CNT_DONE) begin
              r_d     = r_q + 2'd1;
              state_d = ST_SCAN;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end

    row_d = ~(4'b0001 << r_d);
  end

  // State register for the scanner, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_SCAN;
      div_q   <= '0;
      r_q     <= 2'd0;
      row_q   <= 4'b1110;
      cnt_q   <= '0;
      kr_q    <= 2'd0;
      kc_q    <= 2'd0;
      code_q  <= 4'h0;
      value_q <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      r_q     <= r_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      kr_q    <= kr_d;
      kc_q    <= kc_d;
      code_q  <= code_d;
      value_q <= value_d;
      valid_q <= valid_d;
    end
  end

  assign row_o       = row_q;
  assign key_valid_o = valid_q;
  assign key_code_o  = code_q;
  assign value_o     = value_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE=2.
// A small keypad model pulls a column low whenever a held key sits on the
// row currently driven low.
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col_i;
  logic [3:0]  row_o;
  logic        key_valid_o;
  logic [3:0]  key_code_o;
  logic [31:0] value_o;

  logic [15:0] keys;          // bit k = key with code k held down
  int          n_cmp  = 0;
  int          n_err  = 0;
  int          n_pulses = 0;
  int          base;
  logic [31:0] exp_val;
  logic [3:0]  rows [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .col_i       (col_i),
    .row_o       (row_o),
    .key_valid_o (key_valid_o),
    .key_code_o  (key_code_o),
    .value_o     (value_o)
  );

  always #5 clk = ~clk;

  // Physical keypad: a held key connects its column to its row.
  always @* begin
    col_i = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_o[r]) col_i[c] = 1'b0;
  end

  // Count confirm pulses seen at clock edges.
  always @(posedge clk) if (key_valid_o) n_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a confirm pulse; returns sampled just after its edge.
  task automatic wait_pulse(input string tag, input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      cyc(1);
      if (key_valid_o) seen = 1'b1;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    rst  = 1'b0;
    keys = 16'h0;

    // 1. Reset and idle row scan.
    cyc(3);
    check("rst_row",   32'(row_o), 32'hE);
    check("rst_value", value_o, 32'h0);
    check("rst_valid", 32'(key_valid_o), 32'h0);
    check("rst_code",  32'(key_code_o), 32'h0);
    rst = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      cyc(1);
      check($sformatf("idle_row_%0d", k), 32'(row_o), 32'(rows[(k / 4) % 4]));
    end

    // 2. Clean press of row1/col2.
    keys = 16'h1 << 6;
    wait_pulse("k6", 200);
    check("k6_code",  32'(key_code_o), 32'h6);
    check("k6_value", value_o, 32'h6);
    cyc(1);
    check("k6_pulse_width", 32'(key_valid_o), 32'h0);
    keys = 16'h0;
    cyc(40);
    check("k6_pulses", 32'(n_pulses), 32'd1);
    exp_val = 32'h6;

    // 3. Enter 1..9 with releases in between.
    base = n_pulses;
    for (int d = 1; d <= 9; d++) begin
      keys = 16'h1 << d;
      wait_pulse($sformatf("d%0d", d), 200);
      exp_val = {exp_val[27:0], 4'(d)};
      check($sformatf("d%0d_code", d), 32'(key_code_o), 32'(d));
      check($sformatf("d%0d_value", d), value_o, exp_val);
      keys = 16'h0;
      cyc(40);
    end
    check("digits_value",  value_o, 32'h23456789);
    check("digits_pulses", 32'(n_pulses - base), 32'd9);

    // 4. Bounce: key 8 (row2/col0) low for one tick only.
    base = n_pulses;
    for (int i = 0; i < 20 && row_o == 4'hB; i++) cyc(1);
    for (int i = 0; i < 20 && row_o != 4'hB; i++) cyc(1);
    check("bounce_sync_row", 32'(row_o), 32'hB);
    keys = 16'h1 << 8;
    cyc(4);
    check("bounce_row_held", 32'(row_o), 32'hB);
    keys = 16'h0;
    cyc(4);
    check("bounce_next_row", 32'(row_o), 32'h7);
    cyc(40);
    check("bounce_pulses", 32'(n_pulses - base), 32'd0);
    check("bounce_value",  value_o, 32'h23456789);

    // 5. Row0 col1 + col3 together, then release col1 only.
    base = n_pulses;
    keys = 16'h000A;
    wait_pulse("dual1", 200);
    check("dual1_code", 32'(key_code_o), 32'h1);
    keys = 16'h0008;
    wait_pulse("dual3", 300);
    check("dual3_code",  32'(key_code_o), 32'h3);
    check("dual3_value", value_o, 32'h45678913);
    keys = 16'h0;
    cyc(40);
    check("dual_pulses", 32'(n_pulses - base), 32'd2);

    // 6. Reset during HOLD with key A still held.
    keys = 16'h1 << 10;
    wait_pulse("ka", 200);
    check("ka_value", value_o, 32'h5678913A);
    cyc(5);
    rst = 1'b0;
    cyc(2);
    check("midrst_row",   32'(row_o), 32'hE);
    check("midrst_value", value_o, 32'h0);
    check("midrst_code",  32'(key_code_o), 32'h0);
    check("midrst_valid", 32'(key_valid_o), 32'h0);
    base = n_pulses;
    rst = 1'b1;
    wait_pulse("ka_again", 300);
    check("ka_again_code",  32'(key_code_o), 32'hA);
    check("ka_again_value", value_o, 32'hA);
    cyc(40);
    check("ka_again_pulses", 32'(n_pulses - base), 32'd1);
    check("total_pulses",    32'(n_pulses), 32'd14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
